// File: rtl/io_hub.sv
// Processor I/O hub: single-word holding registers per input channel and a FIFO per output channel.
// Define IO_HUB_ERR_EN to add the sticky out-of-range error port err[1:0].
module io_hub #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 4,
  localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           addr_in,
  output logic [NUBITS-1:0]        proc_in,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           addr_out,
  input  logic [NUBITS-1:0]        proc_out,
  output logic                     proc_stall,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_valid,
  input  logic [NUIOOU-1:0]        out_ready,
  output logic [NUIOIN-1:0]        req_in,
  output logic [NUIOOU-1:0]        out_en
`ifdef IO_HUB_ERR_EN
  ,
  output logic [1:0]               err
`endif
);
  logic [NUIOIN-1:0][NUBITS-1:0] r_hold;
  logic [NUIOIN-1:0]             r_full;
  logic [NUIOIN-1:0]             w_rd_sel;
  logic [NUIOOU-1:0]             w_wr_sel, w_room, w_push, w_pop, w_valid;
  logic [NUIOOU-1:0][NUBITS-1:0] w_head;
  logic [NUBITS-1:0]             w_rd_data;
  logic w_rd_req, w_rd_full, w_rd_acc, w_rd_stall;
  logic w_wr_req, w_wr_room, w_wr_acc, w_wr_stall;

  // Out-of-range addresses decode to an all-zero select: no data, no strobe, no stall.
  always_comb begin
    w_rd_sel  = '0;
    w_wr_sel  = '0;
    w_rd_data = '0;
    for (int i = 0; i < NUIOIN; i++) w_rd_sel[i] = (addr_in == AIW'(i));
    for (int j = 0; j < NUIOOU; j++) w_wr_sel[j] = (addr_out == AOW'(j));
    for (int i = 0; i < NUIOIN; i++) if (w_rd_sel[i]) w_rd_data = r_hold[i];
  end

  assign w_rd_req   = rst & proc_req_in;
  assign w_rd_full  = |(w_rd_sel & r_full);
  assign w_rd_acc   = w_rd_req & w_rd_full;
  assign w_rd_stall = w_rd_req & (|w_rd_sel) & ~w_rd_full;

  assign w_wr_req   = rst & proc_out_en;
  assign w_wr_room  = |(w_wr_sel & w_room);
  assign w_wr_acc   = w_wr_req & w_wr_room;
  assign w_wr_stall = w_wr_req & (|w_wr_sel) & ~w_wr_room;

  assign proc_in    = w_rd_data;
  assign proc_stall = w_rd_stall | w_wr_stall;
  assign req_in     = w_rd_acc ? w_rd_sel : '0;
  assign out_en     = w_wr_acc ? w_wr_sel : '0;
  assign in_ready   = rst ? ~r_full : '0;

  for (genvar i = 0; i < NUIOIN; i++) begin : g_in
    // Load and read-clear never coincide: load needs empty, read needs full.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_hold[i] <= '0;
        r_full[i] <= 1'b0;
      end else if (in_valid[i] && !r_full[i]) begin
        r_hold[i] <= in_data[i*NUBITS +: NUBITS];
        r_full[i] <= 1'b1;
      end else if (req_in[i]) begin
        r_full[i] <= 1'b0;
      end
    end
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    assign w_push[j] = out_en[j];
    assign w_pop[j]  = w_valid[j] & out_ready[j];
    io_hub_ofifo #(.W(NUBITS), .DEPTH(FDEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push[j]),
      .i_din  (proc_out),
      .i_pop  (w_pop[j]),
      .o_head (w_head[j]),
      .o_valid(w_valid[j]),
      .o_room (w_room[j])
    );
    assign out_data[j*NUBITS +: NUBITS] = w_head[j];
  end
  assign out_valid = w_valid;

`ifdef IO_HUB_ERR_EN
  logic [1:0] r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 2'b00;
    else begin
      if (proc_req_in && !(|w_rd_sel)) r_err[0] <= 1'b1;
      if (proc_out_en && !(|w_wr_sel)) r_err[1] <= 1'b1;
    end
  end
  assign err = r_err;
`endif
endmodule

// Output FIFO: head is registered storage, so a push to an empty FIFO shows valid one cycle later.
module io_hub_ofifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic         o_room
);
  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wp, r_rp;
  logic [PW:0]             r_cnt;

  assign o_head  = r_mem[r_rp];
  assign o_valid = (r_cnt != '0);
  assign o_room  = (r_cnt < (PW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + 1'b1;
      end
      if (i_pop) r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_io_hub.sv
// Directed bench for io_hub with 3 input and 3 output channels so out-of-range addresses exist.
module tb_io_hub;
  localparam int NB = 32;
  localparam int NI = 3;
  localparam int NO = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           proc_req_in, proc_out_en, proc_stall;
  logic [1:0]     addr_in, addr_out;
  logic [NB-1:0]  proc_in, proc_out;
  logic [NI*NB-1:0] in_data;
  logic [NI-1:0]  in_valid, in_ready, req_in;
  logic [NO*NB-1:0] out_data;
  logic [NO-1:0]  out_valid, out_ready, out_en;
`ifdef IO_HUB_ERR_EN
  logic [1:0]     err;
`endif

  int n_vec = 0;
  int n_err = 0;

  io_hub #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_in(proc_in),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_out(proc_out),
    .proc_stall(proc_stall),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .req_in(req_in), .out_en(out_en)
`ifdef IO_HUB_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] od(input int j);
    return out_data[j*NB +: NB];
  endfunction

  initial begin
    rst = 1'b0; proc_req_in = 0; proc_out_en = 1'b1; addr_in = 0; addr_out = 0;
    proc_out = 32'h55; in_data = '0; in_valid = '0; out_ready = '0;
    #3;
    check("rst_in_ready", in_ready, 3'b000);
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_out_en", out_en, 3'b000);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_proc_in", proc_in, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk); rst = 1'b1; proc_out_en = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 3'b111);
    check("post_rst_out_valid", out_valid, 3'b000);

    // input channel load then read
    @(negedge clk); in_valid = 3'b010; in_data[NB +: NB] = 32'h0000_1234;
    #1 check("ld_in_ready", in_ready, 3'b111);
    @(negedge clk); in_valid = '0; proc_req_in = 1; addr_in = 1;
    #1 check("rd1_data", proc_in, 32'h1234);
    check("rd1_req_in", req_in, 3'b010);
    check("rd1_stall", proc_stall, 1'b0);
    check("rd1_in_ready", in_ready, 3'b101);
    @(negedge clk); proc_req_in = 0;
    #1 check("rd1_after_ready", in_ready, 3'b111);

    // empty read stalls until a word arrives
    @(negedge clk); proc_req_in = 1; addr_in = 0;
    #1 check("empty_stall", proc_stall, 1'b1);
    check("empty_req_in", req_in, 3'b000);
    @(negedge clk); in_valid = 3'b001; in_data[0 +: NB] = 32'hAAAA;
    #1 check("empty_stall2", proc_stall, 1'b1);
    @(negedge clk); in_valid = '0;
    #1 check("empty_done_stall", proc_stall, 1'b0);
    check("empty_done_req", req_in, 3'b001);
    check("empty_done_data", proc_in, 32'hAAAA);
    @(negedge clk); proc_req_in = 0;

    // FIFO fill to depth, fifth write stalls even with a same-cycle pop
    for (int k = 1; k <= 4; k++) begin
      proc_out_en = 1; addr_out = 0; proc_out = k;
      #1 check("fill_out_en", out_en, 3'b001);
      check("fill_stall", proc_stall, 1'b0);
      check("fill_valid", out_valid[0], (k > 1));
      @(negedge clk);
    end
    proc_out = 5;
    #1 check("full_stall", proc_stall, 1'b1);
    check("full_out_en", out_en, 3'b000);
    check("full_head", od(0), 1);
    @(negedge clk); out_ready = 3'b001;
    #1 check("full_pop_stall", proc_stall, 1'b1);
    check("full_pop_out_en", out_en, 3'b000);
    @(negedge clk);
    #1 check("room_stall", proc_stall, 1'b0);
    check("room_out_en", out_en, 3'b001);
    check("room_head", od(0), 2);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk); proc_out_en = 0;
      #1 check("drain_head", od(0), k);
      check("drain_valid", out_valid[0], 1'b1);
    end
    @(negedge clk);
    #1 check("drain_empty", out_valid[0], 1'b0);
    out_ready = '0;

    // concurrent push+pop and concurrent read+write
    @(negedge clk); in_valid = 3'b100; in_data[2*NB +: NB] = 32'hBEEF;
    proc_out_en = 1; addr_out = 1; proc_out = 10;
    #1 check("c_push10", out_en, 3'b010);
    @(negedge clk); in_valid = '0; proc_out = 11;
    #1 check("c_valid1", out_valid[1], 1'b1);
    @(negedge clk); proc_out = 12; out_ready = 3'b010; proc_req_in = 1; addr_in = 2;
    #1 check("c_req_in", req_in, 3'b100);
    check("c_out_en", out_en, 3'b010);
    check("c_stall", proc_stall, 1'b0);
    check("c_proc_in", proc_in, 32'hBEEF);
    check("c_head10", od(1), 10);
    @(negedge clk); proc_req_in = 1; addr_in = 0; out_ready = '0; proc_out = 13;
    #1 check("c_rdstall", proc_stall, 1'b1);
    check("c_rdstall_req", req_in, 3'b000);
    check("c_wr_completes", out_en, 3'b010);
    check("c_head11", od(1), 11);
    @(negedge clk); proc_req_in = 0; proc_out_en = 0; out_ready = 3'b010;
    for (int k = 11; k <= 13; k++) begin
      #1 check("c_order", od(1), k);
      @(negedge clk);
    end
    #1 check("c_empty", out_valid[1], 1'b0);
    out_ready = '0;

    // out-of-range accesses
    @(negedge clk); proc_req_in = 1; addr_in = 3;
    #1 check("oor_rd_data", proc_in, 0);
    check("oor_rd_stall", proc_stall, 1'b0);
    check("oor_rd_req", req_in, 3'b000);
    @(negedge clk); proc_req_in = 0; proc_out_en = 1; addr_out = 3; proc_out = 32'h99;
`ifdef IO_HUB_ERR_EN
    #1 check("err_rd", err, 2'b01);
`else
    #1;
`endif
    check("oor_wr_en", out_en, 3'b000);
    check("oor_wr_stall", proc_stall, 1'b0);
    @(negedge clk); proc_out_en = 0;
    #1 check("oor_wr_dropped", out_valid, 3'b000);
`ifdef IO_HUB_ERR_EN
    check("err_wr", err, 2'b11);
`endif

    // reset mid-transfer discards buffered words
    @(negedge clk); in_valid = 3'b001; in_data[0 +: NB] = 32'h77;
    for (int k = 21; k <= 23; k++) begin
      proc_out_en = 1; addr_out = 1; proc_out = k;
      @(negedge clk); in_valid = '0;
    end
    proc_out_en = 0; addr_in = 0;
    #1 check("mr_valid_pre", out_valid, 3'b010);
    check("mr_hold_pre", proc_in, 32'h77);
    #2 rst = 1'b0;
    #1 check("mr_valid", out_valid, 3'b000);
    check("mr_in_ready", in_ready, 3'b000);
    check("mr_proc_in", proc_in, 0);
    check("mr_out_data", od(1), 0);
    @(negedge clk); rst = 1'b1;
    #1 check("mr_rel_ready", in_ready, 3'b111);
    check("mr_rel_valid", out_valid, 3'b000);
`ifdef IO_HUB_ERR_EN
    check("mr_err", err, 2'b00);
`endif
    proc_out_en = 1; addr_out = 1; proc_out = 32'h31;
    @(negedge clk); proc_out_en = 0;
    #1 check("mr_push_valid", out_valid, 3'b010);
    check("mr_push_head", od(1), 32'h31);
    @(negedge clk); out_ready = 3'b010;
    #1 check("mr_push_one", out_valid[1], 1'b1);
    @(negedge clk);
    #1 check("mr_cnt_was_1", out_valid[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
